// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter shared types and constants.
// Arbiter state encoding, ctrl stall bit positions and bus width.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle    = 2'd0,
        ArbBusyMem = 2'd1,
        ArbBusyIf  = 2'd2
    } arb_state_e;

    localparam int StallIfBit  = 1;
    localparam int StallMemBit = 4;
    localparam int RegBus      = 32;

    localparam logic [3:0] SelAll = 4'b1111;

endpackage

// File: rtl/bus_arbiter.sv
// Shares one Wishbone-classic master between instruction fetch and data access.
// Data port wins ties; completed results are held until the owning stage advances.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_stallreq_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_stallreq_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i
);

    arb_state_e        state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [DATA_W-1:0] if_buf_q, if_buf_d;
    logic [DATA_W-1:0] mem_buf_q, mem_buf_d;
    logic              done_if_q, done_if_d;
    logic              done_mem_q, done_mem_d;
    logic              discard_q, discard_d;

    logic unused_stall;
    assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        if_buf_d   = if_buf_q;
        mem_buf_d  = mem_buf_q;
        discard_d  = discard_q;
        done_if_d  = done_if_q & stall_i[StallIfBit] & ~flush_i;
        done_mem_d = done_mem_q & stall_i[StallMemBit] & ~flush_i;

        unique case (state_q)
            ArbIdle: begin
                if (mem_ce_i && !done_mem_q && !flush_i) begin
                    state_d = ArbBusyMem;
                    cyc_d   = 1'b1;
                    we_d    = mem_we_i;
                    sel_d   = mem_sel_i;
                    adr_d   = mem_addr_i;
                    dat_d   = mem_data_i;
                end else if (if_ce_i && !done_if_q && !flush_i) begin
                    state_d = ArbBusyIf;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = SelAll;
                    adr_d   = if_addr_i;
                end
            end
            ArbBusyMem, ArbBusyIf: begin
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                if (wb_ack_i) begin
                    state_d   = ArbIdle;
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    discard_d = 1'b0;
                    // An ack outranks a same-cycle release of the buffer
                    if (!discard_q) begin
                        if (state_q == ArbBusyMem) begin
                            done_mem_d = 1'b1;
                            if (!we_q) begin
                                mem_buf_d = wb_dat_i;
                            end
                        end else begin
                            done_if_d = 1'b1;
                            if_buf_d  = wb_dat_i;
                        end
                    end
                end
            end
            default: begin
                state_d = ArbIdle;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ArbIdle;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            if_buf_q   <= '0;
            mem_buf_q  <= '0;
            done_if_q  <= 1'b0;
            done_mem_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            if_buf_q   <= if_buf_d;
            mem_buf_q  <= mem_buf_d;
            done_if_q  <= done_if_d;
            done_mem_q <= done_mem_d;
            discard_q  <= discard_d;
        end
    end

    assign if_stallreq_o  = if_ce_i & ~done_if_q;
    assign mem_stallreq_o = mem_ce_i & ~done_mem_q;
    assign if_data_o      = if_buf_q;
    assign mem_data_o     = mem_buf_q;
    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = cyc_q;
    assign wb_we_o        = we_q;
    assign wb_sel_o       = sel_q;
    assign wb_adr_o       = adr_q;
    assign wb_dat_o       = dat_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, directed corners,
// and randomized traffic against a transaction-level reference model.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_stallreq_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_stallreq_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .if_ce_i       (if_ce_i),
        .if_addr_i     (if_addr_i),
        .if_data_o     (if_data_o),
        .if_stallreq_o (if_stallreq_o),
        .mem_ce_i      (mem_ce_i),
        .mem_we_i      (mem_we_i),
        .mem_sel_i     (mem_sel_i),
        .mem_addr_i    (mem_addr_i),
        .mem_data_i    (mem_data_i),
        .mem_data_o    (mem_data_o),
        .mem_stallreq_o(mem_stallreq_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_sel_o      (wb_sel_o),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_dat_i      (wb_dat_i),
        .wb_ack_i      (wb_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i    = 6'b0;
        flush_i    = 1'b0;
        if_ce_i    = 1'b0;
        if_addr_i  = '0;
        mem_ce_i   = 1'b0;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'b0;
        mem_addr_i = '0;
        mem_data_i = '0;
        wb_dat_i   = '0;
        wb_ack_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ce;
        logic        stl;
        logic        ack;
        logic [31:0] dat;
        logic        ecyc;
        logic        estall;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl[11];

    // Reference model state (transaction view)
    int          m_owner;
    bit          m_disc;
    bit          m_dif;
    bit          m_dmem;
    logic [31:0] m_ifb;
    logic [31:0] m_memb;
    logic [31:0] m_adr;
    logic [31:0] m_dat;
    logic [3:0]  m_sel;
    bit          m_we;

    task automatic model_step();
        int          own;
        bit          n_dif;
        bit          n_dmem;
        own    = m_owner;
        n_dif  = m_dif && stall_i[1] && !flush_i;
        n_dmem = m_dmem && stall_i[4] && !flush_i;
        if (own == 0) begin
            if (!flush_i && mem_ce_i && !m_dmem) begin
                m_owner = 1;
                m_adr   = mem_addr_i;
                m_we    = mem_we_i;
                m_sel   = mem_sel_i;
                m_dat   = mem_data_i;
            end else if (!flush_i && if_ce_i && !m_dif) begin
                m_owner = 2;
                m_adr   = if_addr_i;
                m_we    = 1'b0;
                m_sel   = 4'hF;
            end
        end else begin
            bit nd;
            nd = m_disc | flush_i;
            if (wb_ack_i) begin
                if (!m_disc) begin
                    if (own == 1) begin
                        n_dmem = 1'b1;
                        if (!m_we) m_memb = wb_dat_i;
                    end else begin
                        n_dif = 1'b1;
                        m_ifb = wb_dat_i;
                    end
                end
                nd      = 1'b0;
                m_owner = 0;
                m_we    = 1'b0;
            end
            m_disc = nd;
        end
        m_dif  = n_dif;
        m_dmem = n_dmem;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // Reset state
        chk("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'b0, wb_stb_o}, 32'd0);
        chk("rst_we", {31'b0, wb_we_o}, 32'd0);
        chk("rst_sel", {28'b0, wb_sel_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_ifdata", if_data_o, 32'd0);
        if_ce_i  = 1'b1;
        mem_ce_i = 1'b1;
        #1;
        chk("rst_ifstall", {31'b0, if_stallreq_o}, 32'd1);
        chk("rst_memstall", {31'b0, mem_stallreq_o}, 32'd1);
        idle_inputs();

        // IF read of 0x100, slave acks at k=2
        tbl[0]  = '{1, 1, 0, 32'h0, 0, 1, 32'h0};
        tbl[1]  = '{1, 1, 0, 32'h0, 1, 1, 32'h0};
        tbl[2]  = '{1, 1, 0, 32'h0, 1, 1, 32'h0};
        tbl[3]  = '{1, 1, 1, 32'h3C011234, 1, 1, 32'h0};
        tbl[4]  = '{1, 1, 0, 32'h0, 0, 0, 32'h3C011234};
        tbl[5]  = '{1, 1, 0, 32'h0, 0, 0, 32'h3C011234};
        tbl[6]  = '{1, 0, 0, 32'h0, 0, 0, 32'h3C011234};
        tbl[7]  = '{0, 0, 0, 32'h0, 0, 0, 32'h3C011234};
        tbl[8]  = '{1, 0, 0, 32'h0, 0, 1, 32'h3C011234};
        tbl[9]  = '{0, 0, 1, 32'h00000001, 1, 0, 32'h3C011234};
        tbl[10] = '{0, 0, 0, 32'h0, 0, 0, 32'h00000001};
        if_addr_i = 32'h100;
        for (int i = 0; i < 11; i++) begin
            if_ce_i    = tbl[i].ce;
            stall_i[1] = tbl[i].stl;
            wb_ack_i   = tbl[i].ack;
            wb_dat_i   = tbl[i].dat;
            #1;
            chk($sformatf("tbl%0d_cyc", i), {31'b0, wb_cyc_o},
                {31'b0, tbl[i].ecyc});
            chk($sformatf("tbl%0d_ifstall", i), {31'b0, if_stallreq_o},
                {31'b0, tbl[i].estall});
            chk($sformatf("tbl%0d_ifdata", i), if_data_o, tbl[i].edata);
            if (tbl[i].ecyc) begin
                chk($sformatf("tbl%0d_adr", i), wb_adr_o, 32'h100);
                chk($sformatf("tbl%0d_sel", i), {28'b0, wb_sel_o}, 32'hF);
                chk($sformatf("tbl%0d_we", i), {31'b0, wb_we_o}, 32'd0);
            end
            tick();
        end
        idle_inputs();

        // Simultaneous requests: MEM load first, IF after one idle cycle
        stall_i    = 6'b010010;
        if_ce_i    = 1'b1;
        if_addr_i  = 32'h200;
        mem_ce_i   = 1'b1;
        mem_addr_i = 32'h80;
        mem_sel_i  = 4'hF;
        tick();
        chk("sim_n1_cyc", {31'b0, wb_cyc_o}, 32'd1);
        chk("sim_n1_adr", wb_adr_o, 32'h80);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEADBEEF;
        tick();
        wb_ack_i = 1'b0;
        #1;
        chk("sim_n2_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("sim_n2_memdata", mem_data_o, 32'hDEADBEEF);
        chk("sim_n2_memstall", {31'b0, mem_stallreq_o}, 32'd0);
        chk("sim_n2_ifstall", {31'b0, if_stallreq_o}, 32'd1);
        tick();
        chk("sim_n3_cyc", {31'b0, wb_cyc_o}, 32'd1);
        chk("sim_n3_adr", wb_adr_o, 32'h200);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h24020005;
        tick();
        wb_ack_i = 1'b0;
        #1;
        chk("sim_n4_ifdata", if_data_o, 32'h24020005);
        chk("sim_n4_memhold", mem_data_o, 32'hDEADBEEF);
        idle_inputs();
        tick();

        // Store: outputs stable until ack
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b1;
        mem_sel_i  = 4'b0011;
        mem_addr_i = 32'h40;
        mem_data_i = 32'h11223344;
        stall_i    = 6'b010000;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("st%0d_we", k), {31'b0, wb_we_o}, 32'd1);
            chk($sformatf("st%0d_sel", k), {28'b0, wb_sel_o}, 32'h3);
            chk($sformatf("st%0d_dat", k), wb_dat_o, 32'h11223344);
            chk($sformatf("st%0d_adr", k), wb_adr_o, 32'h40);
            chk($sformatf("st%0d_stall", k), {31'b0, mem_stallreq_o}, 32'd1);
            if (k == 2) begin
                wb_ack_i = 1'b1;
                wb_dat_i = 32'hFFFFFFFF;
            end
            tick();
        end
        wb_ack_i = 1'b0;
        #1;
        chk("st_after_stall", {31'b0, mem_stallreq_o}, 32'd0);
        chk("st_after_we", {31'b0, wb_we_o}, 32'd0);
        chk("st_after_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("st_after_buf", mem_data_o, 32'hDEADBEEF);
        idle_inputs();
        tick();

        // Flush during BUSY_IF: cycle completes, result dropped
        stall_i   = 6'b000010;
        if_ce_i   = 1'b1;
        if_addr_i = 32'h300;
        tick();
        chk("fl_open", {31'b0, wb_cyc_o}, 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_held", {31'b0, wb_cyc_o}, 32'd1);
        chk("fl_adr", wb_adr_o, 32'h300);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hBADBAD00;
        flush_i  = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        #1;
        chk("fl_noissue", {31'b0, wb_cyc_o}, 32'd0);
        chk("fl_ifdata", if_data_o, 32'h24020005);
        chk("fl_notdone", {31'b0, if_stallreq_o}, 32'd1);
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_still_idle", {31'b0, wb_cyc_o}, 32'd0);
        tick();
        chk("fl_reissue", {31'b0, wb_cyc_o}, 32'd1);

        // Reset mid BUSY_IF with ack pending
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        if_ce_i  = 1'b0;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h55AA55AA;
        #1;
        chk("mr_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("mr_stall_lo", {31'b0, if_stallreq_o}, 32'd0);
        if_ce_i = 1'b1;
        #1;
        chk("mr_stall_hi", {31'b0, if_stallreq_o}, 32'd1);
        if_ce_i = 1'b0;
        tick();
        wb_ack_i = 1'b0;
        if_ce_i  = 1'b1;
        #1;
        chk("mr_late_ack", {31'b0, if_stallreq_o}, 32'd1);
        chk("mr_ifdata", if_data_o, 32'd0);
        idle_inputs();

        // Randomized traffic against the reference model
        do_reset();
        m_owner = 0;
        m_disc  = 0;
        m_dif   = 0;
        m_dmem  = 0;
        m_ifb   = '0;
        m_memb  = '0;
        m_adr   = '0;
        m_dat   = '0;
        m_sel   = '0;
        m_we    = 0;
        for (int c = 0; c < 3000; c++) begin
            stall_i    = 6'($urandom);
            flush_i    = ($urandom_range(0, 19) == 0);
            if_ce_i    = ($urandom_range(0, 9) < 6);
            if_addr_i  = {$urandom} & 32'hFFFF_FFFC;
            mem_ce_i   = ($urandom_range(0, 9) < 5);
            mem_we_i   = $urandom_range(0, 1) == 1;
            mem_sel_i  = 4'($urandom);
            mem_addr_i = $urandom;
            mem_data_i = $urandom;
            wb_dat_i   = $urandom;
            if (m_owner != 0)
                wb_ack_i = ($urandom_range(0, 9) < 4);
            else
                wb_ack_i = ($urandom_range(0, 9) == 0);
            #1;
            chk("rnd_ifstall", {31'b0, if_stallreq_o},
                {31'b0, if_ce_i & ~m_dif});
            chk("rnd_memstall", {31'b0, mem_stallreq_o},
                {31'b0, mem_ce_i & ~m_dmem});
            chk("rnd_cyc", {31'b0, wb_cyc_o}, {31'b0, m_owner != 0});
            chk("rnd_stb", {31'b0, wb_stb_o}, {31'b0, m_owner != 0});
            chk("rnd_we", {31'b0, wb_we_o}, {31'b0, m_we});
            chk("rnd_ifdata", if_data_o, m_ifb);
            chk("rnd_memdata", mem_data_o, m_memb);
            if (m_owner != 0) begin
                chk("rnd_adr", wb_adr_o, m_adr);
                chk("rnd_sel", {28'b0, wb_sel_o}, {28'b0, m_sel});
                if (m_owner == 1)
                    chk("rnd_dat", wb_dat_o, m_dat);
            end
            model_step();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
